// File: rtl/start_sched_pkg.sv
// Shared types and helpers for the round-robin start scheduler.
//   state_t     : scheduler FSM states
//   DATA_W      : operand word width (three FIELD_W fields)
//   pack_fields : builds an operand word from its three fields
//   wrap_add    : modular add used for rotating priority indices
package start_sched_pkg;

    localparam int unsigned FIELD_W = 9;
    localparam int unsigned DATA_W  = 3 * FIELD_W;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Operand word layout: f2 in the top field, f0 in the bottom field.
    function automatic logic [DATA_W-1:0] pack_fields(
        input logic [FIELD_W-1:0] f2,
        input logic [FIELD_W-1:0] f1,
        input logic [FIELD_W-1:0] f0
    );
        return {f2, f1, f0};
    endfunction

    // (a + b) mod n, valid for a < n and b <= n.
    function automatic int unsigned wrap_add(
        input int unsigned a,
        input int unsigned b,
        input int unsigned n
    );
        int unsigned s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/start_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index holding highest priority
//   winner : first set request searching ptr, ptr+1, ... mod N_REQ
//   valid  : at least one request is set
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    import start_sched_pkg::*;

    logic [IDX_W-1:0] idx;

    // Walk outward from ptr; the first hit is kept.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = IDX_W'(wrap_add(32'(ptr), i, N_REQ));
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/start_rr_scheduler.sv
// Round-robin scheduler sharing one start/done engine between N_REQ
// requesters. Grants one requester, latches its operand, pulses start_o,
// then waits for done_i or a watchdog abort before serving the next one.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset
//   req_i     : per-requester request, held until granted
//   data_i    : packed operands, requester k at [k*DATA_W +: DATA_W]
//   done_i    : engine completion pulse
//   gnt_o     : one-hot grant pulse
//   owner_o   : index of requester being served
//   start_o   : engine start pulse
//   data_o    : operand latched on the grant edge
//   busy_o    : high from grant until return to IDLE
//   timeout_o : pulse on watchdog abort
module start_rr_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 27,
    parameter int unsigned TIMEOUT = 63,
    localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    input  logic                      done_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [IDX_W-1:0]          owner_o,
    output logic                      start_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    import start_sched_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [IDX_W-1:0]   owner_d;
    logic               start_d;
    logic [DATA_W-1:0]  data_d;
    logic               busy_d;
    logic               timeout_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [DATA_W-1:0]  data_arr [N_REQ];

    // Unpack the operand bus so the winner can index it directly.
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign data_arr[k] = data_i[k*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_o     <= '0;
            owner_o   <= '0;
            start_o   <= 1'b0;
            data_o    <= '0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_o     <= gnt_d;
            owner_o   <= owner_d;
            start_o   <= start_d;
            data_o    <= data_d;
            busy_o    <= busy_d;
            timeout_o <= timeout_d;
        end
    end

    // Next-state and next-output logic. done_i is only looked at in WAIT,
    // so a done on the grant edge or while idle has no effect.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        owner_d   = owner_o;
        start_d   = 1'b0;
        data_d    = data_o;
        busy_d    = busy_o;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = WAIT;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    start_d = 1'b1;
                    data_d  = data_arr[pick_idx];
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (done_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = IDX_W'(wrap_add(32'(owner_o), 1, N_REQ));
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    ptr_d     = IDX_W'(wrap_add(32'(owner_o), 1, N_REQ));
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_start_rr_scheduler.sv
// Directed bench for start_rr_scheduler (N_REQ=4, TIMEOUT=63).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_start_rr_scheduler;

    import start_sched_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 27;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data = '0;
    logic            done = 1'b0;
    logic [N-1:0]    gnt;
    logic [1:0]      owner;
    logic            start;
    logic [DW-1:0]   data_out;
    logic            busy;
    logic            timeout;

    int checks   = 0;
    int failures = 0;

    start_rr_scheduler dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .req_i     (req),
        .data_i    (data),
        .done_i    (done),
        .gnt_o     (gnt),
        .owner_o   (owner),
        .start_o   (start),
        .data_o    (data_out),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),      32'h0);
        chk({tag, "_owner"}, 32'(owner),    32'h0);
        chk({tag, "_start"}, 32'(start),    32'h0);
        chk({tag, "_data"},  32'(data_out), 32'h0);
        chk({tag, "_busy"},  32'(busy),     32'h0);
        chk({tag, "_tmo"},   32'(timeout),  32'h0);
    endtask

    int unsigned fair_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset state
        step(3);
        chk_all_zero("rst");
        rst_n = 1'b1;
        step();

        // Fairness: all four requesting, done 3 cycles after each start
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            chk($sformatf("fair%0d_gnt", g), 32'(gnt), 32'(4'b0001 << fair_seq[g]));
            chk($sformatf("fair%0d_own", g), 32'(owner), fair_seq[g]);
            chk($sformatf("fair%0d_start", g), 32'(start), 32'h1);
            if (g == 4) req = '0;
            step();
            chk($sformatf("fair%0d_start_off", g), 32'(start), 32'h0);
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            chk($sformatf("fair%0d_busy_off", g), 32'(busy), 32'h0);
        end
        step();
        chk("fair_idle_gnt", 32'(gnt), 32'h0);
        chk("fair_idle_busy", 32'(busy), 32'h0);

        // Single request with operand capture
        req = 4'b0001;
        data[0 +: DW] = pack_fields(9'd3, 9'd2, 9'd1);
        step();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_start", 32'(start), 32'h1);
        chk("single_data", 32'(data_out), 32'h00C0401);
        chk("single_busy", 32'(busy), 32'h1);
        req = '0;
        data[0 +: DW] = 27'h7FFFFFF;
        step();
        chk("single_hold_data", 32'(data_out), 32'h00C0401);
        chk("single_gnt_off", 32'(gnt), 32'h0);
        step(43);
        chk("single_busy_pre_done", 32'(busy), 32'h1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("single_busy_off", 32'(busy), 32'h0);
        chk("single_tmo", 32'(timeout), 32'h0);

        // Spurious done in IDLE and on the grant edge
        done = 1'b1;
        step();
        chk("spur_idle_busy", 32'(busy), 32'h0);
        req = 4'b0001;
        step();
        chk("spur_gnt_busy", 32'(busy), 32'h1);
        chk("spur_gnt_start", 32'(start), 32'h1);
        done = 1'b0;
        req = '0;
        step();
        chk("spur_still_wait", 32'(busy), 32'h1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("spur_done_busy", 32'(busy), 32'h0);

        // Done on the watchdog expiry edge: done wins
        req = 4'b0001;
        step();
        req = '0;
        step(62);
        chk("coll_busy_pre", 32'(busy), 32'h1);
        chk("coll_tmo_pre", 32'(timeout), 32'h0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("coll_busy", 32'(busy), 32'h0);
        chk("coll_tmo", 32'(timeout), 32'h0);
        step();
        chk("coll_tmo_after", 32'(timeout), 32'h0);

        // Watchdog abort; ptr is 1 so requester 2 wins before 0
        req = 4'b0101;
        step();
        chk("tmo_gnt", 32'(gnt), 32'h4);
        chk("tmo_owner", 32'(owner), 32'h2);
        req = 4'b0001;
        step(62);
        chk("tmo_not_yet", 32'(timeout), 32'h0);
        chk("tmo_busy_pre", 32'(busy), 32'h1);
        step();
        chk("tmo_pulse", 32'(timeout), 32'h1);
        chk("tmo_busy_off", 32'(busy), 32'h0);
        chk("tmo_gnt_off", 32'(gnt), 32'h0);
        step();
        chk("tmo_next_gnt", 32'(gnt), 32'h1);
        chk("tmo_next_owner", 32'(owner), 32'h0);
        chk("tmo_pulse_end", 32'(timeout), 32'h0);
        req = '0;

        // Asynchronous reset mid-WAIT, then grant to requester 1
        step();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("arst");
        step();
        data[1*DW +: DW] = pack_fields(9'h1FF, 9'h000, 9'h0AA);
        req = 4'b0010;
        rst_n = 1'b1;
        step();
        chk("arst_gnt", 32'(gnt), 32'h2);
        chk("arst_owner", 32'(owner), 32'h1);
        chk("arst_data", 32'(data_out), 32'(pack_fields(9'h1FF, 9'h000, 9'h0AA)));
        req = '0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
